control_unit: RTL and testbench

Multi-cycle sequencer for the single-bus RISC datapath. It steps every instruction through a fixed 3-cycle fetch and a per-opcode execute sequence of up to 5 cycles. It drives every register-enable, bus-drive, memory and select/encode strobe of `datapath`. It stalls on memory wait states and supports halt and pause.

---
 rtl/control_unit.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Purpose : multi-cycle sequencer for the single-bus RISC datapath (3-step fetch + up to 5 execute steps); optional branch via CU_BRANCH_EN.
// Latency : strobes decode combinationally from the registered step and ir[31:27]; 4..8 cycles per instruction with no wait states.
// Backpressure: memory steps hold (strobes held high) until mem_ready; stop pauses only at an instruction boundary.
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        stop,
    input  logic        con_ff,
    output logic        pci,
    output logic        pco,
    output logic        iri,
    output logic        iro,
    output logic        mari,
    output logic        maro,
    output logic        mdri,
    output logic        mdro,
    output logic        mem_read,
    output logic        mem_write,
    output logic        opi,
    output logic        ipi,
    output logic        ipo,
    output logic        hii,
    output logic        hio,
    output logic        loi,
    output logic        loo,
    output logic        ryi,
    output logic        ryo,
    output logic        rzhi,
    output logic        rzli,
    output logic        rzho,
    output logic        rzlo,
    output logic        rzo,
    output logic        csigno,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        rin,
    output logic        rout,
    output logic        baout,
    output logic        incpc,
    output logic        con_in,
    output logic        run,
    output logic [2:0]  step
);

    typedef enum logic [3:0] {
        T0    = 4'd0,
        T1    = 4'd1,
        T2    = 4'd2,
        T3    = 4'd3,
        T4    = 4'd4,
        T5    = 4'd5,
        T6    = 4'd6,
        T7    = 4'd7,
        PAUSE = 4'd8,
        HALT  = 4'd9
    } state_t;

    typedef struct packed {
        logic pci;
        logic pco;
        logic iri;
        logic iro;
        logic mari;
        logic maro;
        logic mdri;
        logic mdro;
        logic mem_read;
        logic mem_write;
        logic opi;
        logic ipi;
        logic ipo;
        logic hii;
        logic hio;
        logic loi;
        logic loo;
        logic ryi;
        logic ryo;
        logic rzhi;
        logic rzli;
        logic rzho;
        logic rzlo;
        logic rzo;
        logic csigno;
        logic gra;
        logic grb;
        logic grc;
        logic rin;
        logic rout;
        logic baout;
        logic incpc;
        logic con_in;
    } strobe_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state;
    logic       live;       // low from clear until the first edge after it falls
    logic [4:0] opcode;
    strobe_t    s;

    logic is_ld, is_ldi, is_st, is_alu, is_imm, is_md, is_neg;
    logic is_jr, is_in, is_out, is_mfhi, is_mflo, is_halt, is_br;
    logic [2:0] last_step;
    logic       mem_hold;

    assign opcode = ir[31:27];

    // Opcode class flags
    always_comb begin
        is_ld   = (opcode == OP_LD);
        is_ldi  = (opcode == OP_LDI);
        is_st   = (opcode == OP_ST);
        is_alu  = (opcode >= 5'b00011) && (opcode <= 5'b01011);
        is_imm  = (opcode >= 5'b01100) && (opcode <= 5'b01110);
        is_md   = (opcode == OP_MUL) || (opcode == OP_DIV);
        is_neg  = (opcode == OP_NEG) || (opcode == OP_NOT);
        is_jr   = (opcode == OP_JR);
        is_in   = (opcode == OP_IN);
        is_out  = (opcode == OP_OUT);
        is_mfhi = (opcode == OP_MFHI);
        is_mflo = (opcode == OP_MFLO);
        is_halt = (opcode == OP_HALT);
`ifdef CU_BRANCH_EN
        is_br   = (opcode == 5'b10011);
`else
        is_br   = 1'b0;
`endif
    end

`ifndef CU_BRANCH_EN
    // Branch condition and IR operand fields do not affect sequencing without the branch option.
    logic unused_bits;
    assign unused_bits = ^{ir[26:0], con_ff};
`else
    logic unused_bits;
    assign unused_bits = ^ir[26:0];
`endif

    // Final execute step of the current opcode; single-step ops (and nop/undefined) end at T3
    always_comb begin
        last_step = 3'd3;
        if (is_ld || is_st)
            last_step = 3'd7;
        else if (is_md || is_br)
            last_step = 3'd6;
        else if (is_ldi || is_alu || is_imm)
            last_step = 3'd5;
        else if (is_neg)
            last_step = 3'd4;
    end

    // A memory step stays put until the RAM reports completion
    always_comb begin
        mem_hold = 1'b0;
        if ((state == T1) || ((state == T6) && is_ld) || ((state == T7) && is_st))
            mem_hold = !mem_ready;
    end

    // Step sequencer: fetch, execute, boundary pause, halt
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= T0;
            live  <= 1'b0;
        end else begin
            live <= 1'b1;
            if (!live) begin
                state <= T0;
            end else begin
                case (state)
                    T0: state <= T1;
                    T1, T2, T3, T4, T5, T6, T7: begin
                        if (mem_hold)
                            state <= state;
                        else if ((state == T3) && is_halt)
                            state <= HALT;
                        else if ((state >= T3) && (state[2:0] == last_step))
                            state <= stop ? PAUSE : T0;
                        else
                            state <= state_t'(state + 4'd1);
                    end
                    PAUSE: state <= stop ? PAUSE : T0;
                    HALT:  state <= HALT;
                    default: state <= T0;
                endcase
            end
        end
    end

    // Strobe decode from the registered step and the current opcode
    always_comb begin
        s = '0;
        if (live) begin
            case (state)
                T0: begin
                    s.pco = 1'b1; s.mari = 1'b1; s.incpc = 1'b1;
                end
                T1: begin
                    s.mem_read = 1'b1; s.mdri = 1'b1;
                end
                T2: begin
                    s.mdro = 1'b1; s.iri = 1'b1;
                end
                T3: begin
                    if (is_ld || is_ldi || is_st) begin
                        s.grb = 1'b1; s.baout = 1'b1; s.ryi = 1'b1;
                    end else if (is_alu || is_imm) begin
                        s.grb = 1'b1; s.rout = 1'b1; s.ryi = 1'b1;
                    end else if (is_md) begin
                        s.gra = 1'b1; s.rout = 1'b1; s.ryi = 1'b1;
                    end else if (is_neg) begin
                        s.grb = 1'b1; s.rout = 1'b1; s.rzli = 1'b1;
                    end else if (is_jr) begin
                        s.gra = 1'b1; s.rout = 1'b1; s.pci = 1'b1;
                    end else if (is_in) begin
                        s.ipo = 1'b1; s.gra = 1'b1; s.rin = 1'b1;
                    end else if (is_out) begin
                        s.gra = 1'b1; s.rout = 1'b1; s.opi = 1'b1;
                    end else if (is_mfhi) begin
                        s.hio = 1'b1; s.gra = 1'b1; s.rin = 1'b1;
                    end else if (is_mflo) begin
                        s.loo = 1'b1; s.gra = 1'b1; s.rin = 1'b1;
                    end else if (is_br) begin
                        s.gra = 1'b1; s.rout = 1'b1; s.con_in = 1'b1;
                    end
                end
                T4: begin
                    if (is_ld || is_ldi || is_st || is_imm) begin
                        s.csigno = 1'b1; s.rzli = 1'b1;
                    end else if (is_alu) begin
                        s.grc = 1'b1; s.rout = 1'b1; s.rzli = 1'b1;
                    end else if (is_md) begin
                        s.grb = 1'b1; s.rout = 1'b1; s.rzhi = 1'b1; s.rzli = 1'b1;
                    end else if (is_neg) begin
                        s.rzlo = 1'b1; s.gra = 1'b1; s.rin = 1'b1;
                    end else if (is_br) begin
                        s.pco = 1'b1; s.ryi = 1'b1;
                    end
                end
                T5: begin
                    if (is_ld || is_st) begin
                        s.rzlo = 1'b1; s.mari = 1'b1;
                    end else if (is_ldi || is_alu || is_imm) begin
                        s.rzlo = 1'b1; s.gra = 1'b1; s.rin = 1'b1;
                    end else if (is_md) begin
                        s.rzlo = 1'b1; s.loi = 1'b1;
                    end else if (is_br) begin
                        s.csigno = 1'b1; s.rzli = 1'b1;
                    end
                end
                T6: begin
                    if (is_ld) begin
                        s.mem_read = 1'b1; s.mdri = 1'b1;
                    end else if (is_st) begin
                        s.gra = 1'b1; s.rout = 1'b1; s.mdri = 1'b1;
                    end else if (is_md) begin
                        s.rzho = 1'b1; s.hii = 1'b1;
                    end else if (is_br && con_ff) begin
                        s.rzlo = 1'b1; s.pci = 1'b1;
                    end
                end
                T7: begin
                    if (is_ld) begin
                        s.mdro = 1'b1; s.gra = 1'b1; s.rin = 1'b1;
                    end else if (is_st) begin
                        s.mem_write = 1'b1;
                    end
                end
                default: s = '0;
            endcase
        end
    end

    assign pci       = s.pci;
    assign pco       = s.pco;
    assign iri       = s.iri;
    assign iro       = s.iro;
    assign mari      = s.mari;
    assign maro      = s.maro;
    assign mdri      = s.mdri;
    assign mdro      = s.mdro;
    assign mem_read  = s.mem_read;
    assign mem_write = s.mem_write;
    assign opi       = s.opi;
    assign ipi       = s.ipi;
    assign ipo       = s.ipo;
    assign hii       = s.hii;
    assign hio       = s.hio;
    assign loi       = s.loi;
    assign loo       = s.loo;
    assign ryi       = s.ryi;
    assign ryo       = s.ryo;
    assign rzhi      = s.rzhi;
    assign rzli      = s.rzli;
    assign rzho      = s.rzho;
    assign rzlo      = s.rzlo;
    assign rzo       = s.rzo;
    assign csigno    = s.csigno;
    assign gra       = s.gra;
    assign grb       = s.grb;
    assign grc       = s.grc;
    assign rin       = s.rin;
    assign rout      = s.rout;
    assign baout     = s.baout;
    assign incpc     = s.incpc;
    assign con_in    = s.con_in;

    assign run  = live && (state != PAUSE) && (state != HALT);
    assign step = (live && (state <= T7)) ? state[2:0] : 3'd0;

endmodule

// File: tb/tb_control_unit.sv
// Purpose : directed bench for control_unit; expected strobes come from per-opcode step lists written as strobe names.
// Latency : bench advances one step per cycle, inserting the requested wait cycles on memory steps.
// Backpressure: mem_ready and stop driven by the bench to exercise wait states and pausing.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b1;
    logic        stop = 1'b0;
    logic        con_ff = 1'b0;
    logic pci, pco, iri, iro, mari, maro, mdri, mdro, mem_read, mem_write;
    logic opi, ipi, ipo, hii, hio, loi, loo, ryi, ryo, rzhi, rzli, rzho, rzlo, rzo, csigno;
    logic gra, grb, grc, rin, rout, baout, incpc, con_in, run;
    logic [2:0] step;

    control_unit dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready), .stop(stop), .con_ff(con_ff),
        .pci(pci), .pco(pco), .iri(iri), .iro(iro), .mari(mari), .maro(maro), .mdri(mdri), .mdro(mdro),
        .mem_read(mem_read), .mem_write(mem_write), .opi(opi), .ipi(ipi), .ipo(ipo), .hii(hii), .hio(hio),
        .loi(loi), .loo(loo), .ryi(ryi), .ryo(ryo), .rzhi(rzhi), .rzli(rzli), .rzho(rzho), .rzlo(rzlo),
        .rzo(rzo), .csigno(csigno), .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout),
        .baout(baout), .incpc(incpc), .con_in(con_in), .run(run), .step(step)
    );

    always #5 clock = ~clock;

    string names [33] = '{"pci", "pco", "iri", "iro", "mari", "maro", "mdri", "mdro", "mem_read",
                          "mem_write", "opi", "ipi", "ipo", "hii", "hio", "loi", "loo", "ryi", "ryo",
                          "rzhi", "rzli", "rzho", "rzlo", "rzo", "csigno", "gra", "grb", "grc", "rin",
                          "rout", "baout", "incpc", "con_in"};

    logic [32:0] dut_mask;
    assign dut_mask = {con_in, incpc, baout, rout, rin, grc, grb, gra, csigno, rzo, rzlo, rzho, rzli,
                       rzhi, ryo, ryi, loo, loi, hio, hii, ipo, ipi, opi, mem_write, mem_read, mdro,
                       mdri, maro, mari, iro, iri, pco, pci};

    int total = 0;
    int bad   = 0;

    // expectations published by the stimulus, checked by the compare process
    logic        exp_vld = 1'b0;
    logic [32:0] exp_mask = '0;
    logic        exp_run = 1'b0;
    logic        exp_step_vld = 1'b0;
    logic [2:0]  exp_step = '0;
    string       exp_tag = "reset";
    event        chk_ev;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [32:0] mask_of(input string s);
        logic [32:0] m = '0;
        int start = 0;
        for (int i = 0; i <= s.len(); i++) begin
            if (i == s.len() || s.substr(i, i) == " ") begin
                if (i > start) begin
                    string tok = s.substr(start, i - 1);
                    for (int n = 0; n < 33; n++)
                        if (names[n] == tok) m[n] = 1'b1;
                end
                start = i + 1;
            end
        end
        return m;
    endfunction

    // Full step list (fetch + execute) for one opcode, as strobe-name strings
    string seq [$];
    task automatic build_seq(input logic [4:0] op, input logic con);
        seq.delete();
        seq.push_back("pco mari incpc");
        seq.push_back("mem_read mdri");
        seq.push_back("mdro iri");
        if (op == 5'd0) begin
            seq.push_back("grb baout ryi"); seq.push_back("csigno rzli"); seq.push_back("rzlo mari");
            seq.push_back("mem_read mdri"); seq.push_back("mdro gra rin");
        end else if (op == 5'd1) begin
            seq.push_back("grb baout ryi"); seq.push_back("csigno rzli"); seq.push_back("rzlo gra rin");
        end else if (op == 5'd2) begin
            seq.push_back("grb baout ryi"); seq.push_back("csigno rzli"); seq.push_back("rzlo mari");
            seq.push_back("gra rout mdri"); seq.push_back("mem_write");
        end else if (op >= 5'd3 && op <= 5'd11) begin
            seq.push_back("grb rout ryi"); seq.push_back("grc rout rzli"); seq.push_back("rzlo gra rin");
        end else if (op >= 5'd12 && op <= 5'd14) begin
            seq.push_back("grb rout ryi"); seq.push_back("csigno rzli"); seq.push_back("rzlo gra rin");
        end else if (op == 5'd15 || op == 5'd16) begin
            seq.push_back("gra rout ryi"); seq.push_back("grb rout rzhi rzli");
            seq.push_back("rzlo loi"); seq.push_back("rzho hii");
        end else if (op == 5'd17 || op == 5'd18) begin
            seq.push_back("grb rout rzli"); seq.push_back("rzlo gra rin");
`ifdef CU_BRANCH_EN
        end else if (op == 5'd19) begin
            seq.push_back("gra rout con_in"); seq.push_back("pco ryi"); seq.push_back("csigno rzli");
            seq.push_back(con ? "rzlo pci" : "");
`endif
        end else if (op == 5'd20) seq.push_back("gra rout pci");
        else if (op == 5'd22) seq.push_back("ipo gra rin");
        else if (op == 5'd23) seq.push_back("gra rout opi");
        else if (op == 5'd24) seq.push_back("hio gra rin");
        else if (op == 5'd25) seq.push_back("loo gra rin");
        else seq.push_back("");   // nop, halt and undefined opcodes: silent T3
        if (con) begin end
    endtask

    task automatic expect_idle(input string tag);
        exp_vld = 1'b1; exp_mask = '0; exp_run = 1'b0; exp_step_vld = 1'b0; exp_tag = tag;
    endtask

    task automatic expect_reset(input string tag);
        exp_vld = 1'b1; exp_mask = '0; exp_run = 1'b0; exp_step_vld = 1'b1; exp_step = 3'd0; exp_tag = tag;
    endtask

    // Pulse clear for one edge; returns with the DUT showing T0 of the next fetch
    task automatic do_clear();
        clear = 1'b1;
        expect_reset("clear");
        #1 -> chk_ev;
        @(posedge clock); #1;
        clear = 1'b0;
        expect_reset("post_clear");
        @(posedge clock); #1;
    endtask

    // Runs one instruction starting in T0; w1 = fetch wait cycles, w2 = execute memory-step waits
    task automatic run_instr(input logic [4:0] op, input int w1, input int w2, input int stop_step,
                             input int abort_at, input logic con, output int cycles);
        logic [32:0] m;
        int nw;
        build_seq(op, con);
        ir = {op, 27'h2A5_5A5A};
        con_ff = con;
        cycles = 0;
        for (int k = 0; k < seq.size(); k++) begin
            m = mask_of(seq[k]);
            nw = (k == 1) ? w1 : ((k >= 3 && (m[8] || m[9])) ? w2 : 0);
            for (int w = 0; w <= nw; w++) begin
                mem_ready = (w == nw);
                stop = (stop_step >= 0) && (k >= stop_step);
                exp_vld = 1'b1; exp_mask = m; exp_run = 1'b1;
                exp_step_vld = 1'b1; exp_step = 3'(k);
                exp_tag = $sformatf("op%0d_T%0d", op, k);
                if (k == abort_at) begin
                    @(negedge clock); #1;
                    do_clear();
                    return;
                end
                @(posedge clock); #1;
                cycles++;
            end
        end
        mem_ready = 1'b1;
    endtask

    // Compare process: every negedge, plus on demand right after clear rises
    initial begin
        logic [32:0] drv;
        drv = mask_of("pco iro maro mdro ipo hio loo ryo rzho rzlo rzo rout baout csigno");
        forever begin
            @(negedge clock or chk_ev);
            if (exp_vld) begin
                chk({exp_tag, "_strobes"}, 64'(dut_mask), 64'(exp_mask));
                chk({exp_tag, "_run"}, 64'(run), 64'(exp_run));
                if (exp_step_vld) chk({exp_tag, "_step"}, 64'(step), 64'(exp_step));
                chk({exp_tag, "_one_driver"}, 64'($countones(dut_mask & drv) <= 1), 64'd1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        expect_reset("reset");
        @(posedge clock); #1;
        @(posedge clock); #1;
        clear = 1'b0;              // first cycle after release still shows reset values
        @(posedge clock); #1;

        run_instr(5'd3, 0, 0, -1, -1, 1'b0, c);  chk("cyc_add", c, 6);
        run_instr(5'd3, 0, 0, -1, 4, 1'b0, c);   // clear in the middle of T4
        run_instr(5'd0, 3, 2, -1, -1, 1'b0, c);  chk("cyc_ld_wait", c, 13);
        run_instr(5'd0, 0, 0, -1, -1, 1'b0, c);  chk("cyc_ld", c, 8);
        run_instr(5'd1, 0, 0, -1, -1, 1'b0, c);  chk("cyc_ldi", c, 6);
        run_instr(5'd2, 0, 0, -1, -1, 1'b0, c);  chk("cyc_st", c, 8);
        run_instr(5'd2, 1, 2, -1, -1, 1'b0, c);  chk("cyc_st_wait", c, 11);
        run_instr(5'd11, 0, 0, -1, -1, 1'b0, c); chk("cyc_alu_hi", c, 6);
        run_instr(5'd15, 0, 0, -1, -1, 1'b0, c); chk("cyc_mul", c, 7);
        run_instr(5'd16, 0, 0, -1, -1, 1'b0, c); chk("cyc_div", c, 7);
        run_instr(5'd17, 0, 0, -1, -1, 1'b0, c); chk("cyc_neg", c, 5);
        run_instr(5'd18, 0, 0, -1, -1, 1'b0, c); chk("cyc_not", c, 5);
        run_instr(5'd20, 0, 0, -1, -1, 1'b0, c); chk("cyc_jr", c, 4);
        run_instr(5'd22, 0, 0, -1, -1, 1'b0, c); chk("cyc_in", c, 4);
        run_instr(5'd23, 0, 0, -1, -1, 1'b0, c); chk("cyc_out", c, 4);
        run_instr(5'd24, 0, 0, -1, -1, 1'b0, c); chk("cyc_mfhi", c, 4);
        run_instr(5'd25, 0, 0, -1, -1, 1'b0, c); chk("cyc_mflo", c, 4);
        run_instr(5'd26, 0, 0, -1, -1, 1'b0, c); chk("cyc_nop", c, 4);
        run_instr(5'd30, 0, 0, -1, -1, 1'b0, c); chk("cyc_undef", c, 4);
`ifdef CU_BRANCH_EN
        run_instr(5'd19, 0, 0, -1, -1, 1'b1, c); chk("cyc_br_taken", c, 7);
        run_instr(5'd19, 0, 0, -1, -1, 1'b0, c); chk("cyc_br_not", c, 7);
`else
        run_instr(5'd19, 0, 0, -1, -1, 1'b1, c); chk("cyc_br_as_nop", c, 4);
`endif

        // stop raised in T4 of addi: instruction completes, then pause
        run_instr(5'd12, 0, 0, 4, -1, 1'b0, c);  chk("cyc_addi_stop", c, 6);
        for (int i = 0; i < 3; i++) begin
            expect_idle("pause");
            @(posedge clock); #1;
        end
        stop = 1'b0;
        expect_idle("pause_release");
        @(posedge clock); #1;
        run_instr(5'd13, 0, 0, -1, -1, 1'b0, c); chk("cyc_imm_after_pause", c, 6);

        // halt holds until clear
        run_instr(5'd27, 0, 0, -1, -1, 1'b0, c); chk("cyc_halt", c, 4);
        for (int i = 0; i < 20; i++) begin
            expect_idle("halt");
            @(posedge clock); #1;
        end
        do_clear();
        run_instr(5'd3, 0, 0, -1, -1, 1'b0, c);  chk("cyc_add_after_halt", c, 6);

        exp_vld = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
